// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage: enable/disable
//   constants, fetch FSM state encodings, instruction size and a PC
//   increment helper.
package fetch_unit_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int unsigned INST_BYTES = 4;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    // Sequential PC step; wraps modulo 2^32 (FFFF_FFFC -> 0000_0000).
    function automatic logic [31:0] next_pc(input logic [31:0] pc_in);
        return pc_in + 32'(INST_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Small synchronous FIFO holding {pc, ir} pairs between the memory
//   response and the decoder. Push and pop in the same cycle leave the
//   count unchanged, including when full. Flush empties it in one cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push_i        write data_i (ignored when full and not popping)
//   data_i        entry to write
//   pop_i         remove head (ignored when empty)
//   flush_i       discard all entries (dominates push/pop)
//   data_o        head entry (meaningful only when !empty_o)
//   count_o       number of stored entries
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only if the head leaves this cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            assert (!(push_i && full_o && !pop_i))
                else $error("fetch_fifo overflow");
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. Issues word requests to instruction memory,
//   buffers returned words with their PC and hands them to the decoder.
//   Redirects flush buffered words and drop in-flight responses; halt
//   stops fetching until reset.
// Handshakes:
//   imem: a request transfers on a cycle with imem_req & imem_gnt;
//   imem_req stays high with a stable imem_addr until granted (unless a
//   redirect/halt intervenes). Responses arrive in order on imem_rvalid.
//   decoder: an instruction transfers on a cycle with ir_valid & ir_ready;
//   ir/pc stay stable while ir_valid & !ir_ready.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt       request channel
//   imem_rvalid/imem_rdata            response channel
//   ir/pc/ir_valid/ir_ready           decoder channel
//   redirect_valid/redirect_pc        branch/jump redirect
//   halt/halted                       stop request / stopped status
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d, outst_after;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW:0]   inflight;
    logic          run, flush, issue, rsp_dec, drop_now, push, pop;
    logic [63:0]   head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH_RUN;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (state_q == FETCH_RUN && halt) state_d = FETCH_HALTED;
    end

    // ---------------- FSM: outputs ----------------
    // Words already buffered plus words still in flight may never exceed
    // DEPTH, which is what keeps the FIFO from overflowing.
    always_comb begin
        run      = (state_q == FETCH_RUN);
        halted   = (state_q == FETCH_HALTED);
        inflight = {1'b0, outst_q} + {1'b0, fifo_count};
        imem_req = run & ~rst & ~halt & ~redirect_valid
                   & (inflight < (CW + 1)'(DEPTH));
    end

    assign imem_addr = fetch_pc_q;

    // Halt and redirect both flush; halt wins and leaves the PCs alone.
    assign flush    = run & (halt | redirect_valid);
    assign issue    = imem_req & imem_gnt;
    assign rsp_dec  = imem_rvalid & (outst_q != '0);
    assign drop_now = imem_rvalid & (drop_q != '0);
    assign push     = rsp_dec & (drop_q == '0) & run & ~flush;
    assign pop      = ir_valid & ir_ready;

    // ---------------- datapath next state ----------------
    always_comb begin
        outst_after = outst_q - CW'(rsp_dec);
        outst_d     = outst_after + CW'(issue);
        drop_d      = drop_q - CW'(drop_now);
        fetch_pc_d  = issue ? next_pc(fetch_pc_q) : fetch_pc_q;
        resp_pc_d   = push ? next_pc(resp_pc_q) : resp_pc_q;
        if (flush) begin
            // Everything still in flight after this cycle belongs to the
            // old stream and must be absorbed.
            drop_d = outst_after;
            if (!halt) begin
                fetch_pc_d = {redirect_pc[31:2], 2'b00};
                resp_pc_d  = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rvalid && outst_q == '0))
                else $error("fetch_unit: response with nothing outstanding");
        end
    end

    // ---------------- instruction buffer ----------------
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({resp_pc_q, imem_rdata}),
        .pop_i   (pop),
        .flush_i (flush),
        .data_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        ir_valid = ~fifo_empty;
        ir       = fifo_empty ? 32'h0 : head[31:0];
        pc       = fifo_empty ? 32'h0 : head[63:32];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_full && !pop))
                else $error("fetch_unit: instruction buffer overflow");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir(ir), .pc(pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_bad = 0;
  int lat = 1;
  int gnt_pct = 100;
  int rdy_pct = 100;
  bit auto_ready = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_1111;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t       mem_q[$];
  int          last_due;
  bit          prev_wait;
  logic [31:0] prev_addr;

  initial begin
    mreq_t m;
    int d;
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    last_due = 0;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_q.delete();
        imem_rvalid = 1'b0;
        last_due = 0;
        prev_wait = 1'b0;
      end else begin
        if (prev_wait && !redirect_valid && !halt) begin
          check("req_hold", 32'(imem_req), 32'd1);
          check("addr_hold", imem_addr, prev_addr);
        end
        imem_gnt = (int'($urandom_range(0, 99)) < gnt_pct);
        imem_rvalid = 1'b0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
          m = mem_q.pop_front();
          imem_rvalid = 1'b1;
          imem_rdata = word(m.addr);
        end
        if (imem_req && imem_gnt) begin
          d = cyc + lat;
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          m.addr = imem_addr;
          m.due = d;
          mem_q.push_back(m);
        end
        prev_wait = imem_req && !imem_gnt;
        prev_addr = imem_addr;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    @(negedge clk);
    if (!rst && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL extra_pop: got pc %h, expected no instruction", pc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_pc", pc, mon_exp);
        check("sb_ir", ir, word(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_ready)
      ir_ready = (exp_q.size() != 0) && (int'($urandom_range(0, 99)) < rdy_pct);
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    auto_ready = 1'b1;
    while (exp_q.size() != 0 && k < 600) begin
      step();
      k++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    auto_ready = 1'b0;
    ir_ready = 1'b0;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    auto_ready = 1'b0;
    ir_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    lat = l;
    gnt_pct = 100;
    rdy_pct = 100;
    exp_q.delete();
    step();
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h0);
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] exp_pc;
    int          lat;
    int          gnt_pct;
    int          rdy_pct;
    int          n;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #400000;
    n_vec++;
    n_bad++;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 1, 100, 100, 6};
    vecs[1] = '{32'h0000_0203, 32'h0000_0200, 3, 100, 100, 4};
    vecs[2] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 2, 70, 60, 4};
    vecs[3] = '{32'h0000_1000, 32'h0000_1000, 4, 50, 30, 5};
    vecs[4] = '{32'h0000_07FF, 32'h0000_07FC, 1, 60, 50, 5};
    vecs[5] = '{32'h8000_0002, 32'h8000_0000, 2, 100, 80, 5};

    rst = 1'b1;
    ir_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;

    // Start-up: first request at 0, first word visible two cycles later.
    do_reset(1);
    ir_ready = 1'b1;
    push_exp(32'h0, 6);
    @(negedge clk);
    check("start_req", 32'(imem_req), 32'd1);
    check("start_addr", imem_addr, 32'h0);
    check("start_valid0", 32'(ir_valid), 32'd0);
    step();
    @(negedge clk);
    check("start_addr1", imem_addr, 32'h4);
    check("start_valid1", 32'(ir_valid), 32'd0);
    step();
    @(negedge clk);
    check("start_valid2", 32'(ir_valid), 32'd1);
    wait_drain();

    // Decoder stalled: buffer fills to two words, requests stop, head holds.
    do_reset(1);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_valid", 32'(ir_valid), 32'd1);
      check("stall_pc", pc, 32'h0);
      check("stall_ir", ir, word(32'h0));
      step();
    end
    push_exp(32'h0, 5);
    wait_drain();

    // Pop in the redirect cycle completes, then the buffer is empty.
    do_reset(1);
    repeat (4) step();
    push_exp(32'h0, 1);
    ir_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    @(negedge clk);
    check("rpop_req", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    ir_ready = 1'b0;
    @(negedge clk);
    check("rpop_empty", 32'(ir_valid), 32'd0);
    check("rpop_req1", 32'(imem_req), 32'd1);
    check("rpop_addr", imem_addr, 32'h0000_0040);
    check("rpop_left", 32'(exp_q.size()), 32'd0);
    push_exp(32'h0000_0040, 4);
    wait_drain();

    // Two stale requests in flight at redirect (response may land in the redirect cycle).
    for (int l = 2; l <= 3; l++) begin
      do_reset(l);
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0100;
      @(negedge clk);
      check("stale_req", 32'(imem_req), 32'd0);
      step();
      redirect_valid = 1'b0;
      push_exp(32'h0000_0100, 4);
      wait_drain();
    end

    // Table of redirect targets, latencies and handshake densities.
    do_reset(1);
    for (int v = 0; v < 6; v++) begin
      auto_ready = 1'b0;
      ir_ready = 1'b0;
      step();
      lat = vecs[v].lat;
      gnt_pct = vecs[v].gnt_pct;
      rdy_pct = vecs[v].rdy_pct;
      redirect_valid = 1'b1;
      redirect_pc = vecs[v].start_pc;
      @(negedge clk);
      check("tbl_redir_req", 32'(imem_req), 32'd0);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("tbl_addr", imem_addr, vecs[v].exp_pc);
      push_exp(vecs[v].exp_pc, vecs[v].n);
      wait_drain();
    end

    // Halt with one request outstanding: late response is absorbed.
    do_reset(3);
    step();
    halt = 1'b1;
    @(negedge clk);
    check("halt_req", 32'(imem_req), 32'd0);
    step();
    halt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_valid", 32'(ir_valid), 32'd0);
      check("halt_noreq", 32'(imem_req), 32'd0);
      step();
    end

    // Reset out of HALTED restores normal fetching.
    do_reset(1);
    push_exp(32'h0, 3);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
